// File: rtl/refresh_pkg.sv
// Shared types for the GC-DRAM refresh sequencer.
// REFRESH_VERIFY_EN adds the read-back verify states to ref_state_t.
package refresh_pkg;

    localparam int PEND_MAX_DFLT = 3;

    function automatic int pend_width(input int pend_max);
        return $clog2(pend_max + 1);
    endfunction

    localparam int PEND_W = pend_width(PEND_MAX_DFLT);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        PAUSE,
        DONE
`ifdef REFRESH_VERIFY_EN
        ,
        VERIFY_RD,
        VERIFY_WAIT
`endif
    } ref_state_t;

endpackage

// File: rtl/ref_row_counter.sv
// Row address register for the refresh sequencer: increment, clear or hold,
// with a flag for the final row of a burst.
module ref_row_counter #(
    parameter int ROWS   = 64,
    parameter int ADDR_W = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] row_nxt_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] row_q;
    logic [ADDR_W-1:0] row_d;

    // Clear wins over increment; the only path back to row 0 is a finished burst.
    always_comb begin
        row_d = row_q;
        if (clr_i) begin
            row_d = '0;
        end else if (inc_i) begin
            row_d = row_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign row_nxt_o = row_d;
    assign last_o    = (row_q == ADDR_W'(ROWS - 1));

endmodule

// File: rtl/refresh_sequencer.sv
// Refresh burst sequencer: walks every row with read / write-back, yielding to
// host traffic at row boundaries. Optional read-back verify under REFRESH_VERIFY_EN.
module refresh_sequencer
    import refresh_pkg::*;
#(
    parameter int ROWS     = 64,
    parameter int ADDR_W   = $clog2(ROWS),
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int PEND_MAX = PEND_MAX_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ref_req,
    input  logic              disable_ref,
    input  logic              user_active,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef REFRESH_VERIFY_EN
    ,
    output logic              verify_err
`endif
);

    localparam int PCW   = (pend_width(PEND_MAX) > PEND_W) ? pend_width(PEND_MAX) : PEND_W;
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    ref_state_t        state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [PCW-1:0]    pend_q, pend_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_en_q, mem_wr_en_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              busy_q, done_q;
    logic              lat_last, row_end, row_inc, row_clr, row_last;
    logic [ADDR_W-1:0] row_nxt;
`ifdef REFRESH_VERIFY_EN
    logic              verify_err_q;
`endif

    ref_row_counter #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_row (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (row_inc),
        .clr_i     (row_clr),
        .row_nxt_o (row_nxt),
        .last_o    (row_last)
    );

    assign lat_last = (lat_q == LAT_W'(READ_LAT - 1));

    // Host access and disable are only looked at in IDLE, PAUSE and at row_end.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        row_inc = 1'b0;
        row_clr = 1'b0;
        row_end = 1'b0;
        case (state_q)
            IDLE:  if (pend_q != '0 && !disable_ref && !user_active) state_d = READ;
            READ: begin
                state_d = WAIT;
                lat_d   = '0;
            end
            WAIT: begin
                if (lat_last) state_d = WRITE;
                else          lat_d   = lat_q + LAT_W'(1);
            end
`ifdef REFRESH_VERIFY_EN
            WRITE: state_d = VERIFY_RD;
            VERIFY_RD: begin
                state_d = VERIFY_WAIT;
                lat_d   = '0;
            end
            VERIFY_WAIT: begin
                if (lat_last) row_end = 1'b1;
                else          lat_d   = lat_q + LAT_W'(1);
            end
`else
            WRITE: row_end = 1'b1;
`endif
            PAUSE: if (!disable_ref && !user_active) state_d = READ;
            DONE: begin
                state_d = IDLE;
                row_clr = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (row_end) begin
            if (row_last) begin
                state_d = DONE;
            end else begin
                row_inc = 1'b1;
                state_d = (disable_ref || user_active) ? PAUSE : READ;
            end
        end
    end

    // A request landing on the DONE cycle cancels the decrement.
    always_comb begin
        pend_d     = pend_q;
        overflow_d = overflow_q;
        if (ref_req && state_q != DONE) begin
            if (pend_q == PCW'(PEND_MAX)) overflow_d = 1'b1;
            else                          pend_d     = pend_q + PCW'(1);
        end else if (!ref_req && state_q == DONE) begin
            pend_d = pend_q - PCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            pend_q       <= '0;
            overflow_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef REFRESH_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            pend_q      <= pend_d;
            overflow_q  <= overflow_d;
            mem_wr_en_q <= (state_d == WRITE);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            if (state_q == WAIT && lat_last) mem_wdata_q <= mem_rdata;
`ifdef REFRESH_VERIFY_EN
            mem_rd_en_q <= (state_d == READ) || (state_d == VERIFY_RD);
            if (state_d == READ || state_d == WRITE || state_d == VERIFY_RD) mem_addr_q <= row_nxt;
            if (state_q == VERIFY_WAIT && lat_last && mem_rdata != mem_wdata_q) verify_err_q <= 1'b1;
`else
            mem_rd_en_q <= (state_d == READ);
            if (state_d == READ || state_d == WRITE) mem_addr_q <= row_nxt;
`endif
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
`ifdef REFRESH_VERIFY_EN
    assign verify_err = verify_err_q;
`endif

endmodule

// File: tb/tb_refresh_sequencer.sv
// Self-checking bench for refresh_sequencer (ROWS=4, READ_LAT=1, PEND_MAX=3);
// covers the verify option when REFRESH_VERIFY_EN is defined.
module tb_refresh_sequencer;

    localparam int ROWS     = 4;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 32;
    localparam int READ_LAT = 1;
    localparam int PEND_MAX = 3;
`ifdef REFRESH_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam int RC    = VER ? (2 * READ_LAT + 3) : (READ_LAT + 2);
    localparam int BURST = ROWS * RC + 1;
    localparam int RDS   = VER ? 2 * ROWS : ROWS;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ref_req = 1'b0;
    logic              disable_ref = 1'b0;
    logic              user_active = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy, done, overflow;
`ifdef REFRESH_VERIFY_EN
    logic              verify_err;
`endif

    always #5 clk = ~clk;

    refresh_sequencer #(
        .ROWS     (ROWS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT),
        .PEND_MAX (PEND_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ref_req     (ref_req),
        .disable_ref (disable_ref),
        .user_active (user_active),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .mem_wr_en   (mem_wr_en),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
`ifdef REFRESH_VERIFY_EN
        ,
        .verify_err  (verify_err)
`endif
    );

    // Array model, one cycle read latency; optional corruption of the row-1 re-read.
    logic [DATA_W-1:0] orig [ROWS] = '{32'hC0DE_1111, 32'h5A5A_2222, 32'h0F0F_3333, 32'hFFFF_0004};
    logic [DATA_W-1:0] mem  [ROWS] = '{32'hC0DE_1111, 32'h5A5A_2222, 32'h0F0F_3333, 32'hFFFF_0004};
    logic [DATA_W-1:0] rdata_q = '0;
    logic              vpend = 1'b0;
    logic              corrupt = 1'b0;

    always @(posedge clk) begin
        if (mem_rd_en)
            rdata_q <= mem[mem_addr] ^ ((corrupt && vpend && mem_addr == 2'd1) ? 32'h0000_00FF : 32'h0);
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_wr_en)      vpend <= 1'b1;
        else if (mem_rd_en) vpend <= 1'b0;
    end
    assign mem_rdata = rdata_q;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } sb_t;
    sb_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    // Scoreboard: each first read of a row queues the expected write-back.
    always @(negedge clk) begin
        sb_t e;
        if (mem_rd_en || mem_wr_en) begin
            vectors++;
            if (mem_rd_en && mem_wr_en) begin
                miscompares++;
                $display("FAIL strobe_excl: rd_en=%b wr_en=%b, required not both", mem_rd_en, mem_wr_en);
            end
        end
        if (mem_rd_en) begin
            rd_cnt++;
            if (!(VER && vpend)) begin
                e.a = mem_addr;
                e.d = mem[mem_addr];
                sb.push_back(e);
            end
        end
        if (mem_wr_en) begin
            wr_cnt++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL wb_unexpected: write addr=%0d data=%h with no pending read", mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    miscompares++;
                    $display("FAIL wb_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input string tag, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (mem_rd_en === 1'b1) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: no mem_rd_en within %0d cycles", tag, bound);
        end
    endtask

    task automatic wait_done(input string tag, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (done === 1'b1) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: no done within %0d cycles", tag, bound);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({busy, done, overflow, mem_rd_en, mem_wr_en} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy/done/ovf/rd/wr=%b, expected 00000",
                     {busy, done, overflow, mem_rd_en, mem_wr_en});
        end
        vectors++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%0d wdata=%h, expected 0/0", mem_addr, mem_wdata);
        end
        rst = 1'b1;
        repeat (10) tick();
        vectors++;
        if (busy !== 1'b0 || rd_cnt != 0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b reads=%0d, expected 0/0", busy, rd_cnt);
        end
    endtask

    task automatic test_single_burst();
        int waited, base_rd, base_done;
        bit ok, erd, ewr, edn;
        logic [ADDR_W-1:0] eaddr;
        base_rd   = rd_cnt;
        base_done = done_cnt;
        ref_req = 1'b1; tick(); ref_req = 1'b0;
        waited = 0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_rd_en === 1'b1) ok = 1'b1;
            else begin tick(); waited++; end
        end
        vectors++;
        if (!ok || waited != 1) begin
            miscompares++;
            $display("FAIL start_latency: first read after %0d cycles (seen=%b), expected 1", waited, ok);
            return;
        end
        for (int k = 0; k < BURST; k++) begin
            erd   = (k < BURST - 1) && ((k % RC == 0) || (VER && k % RC == 3));
            ewr   = (k < BURST - 1) && (k % RC == 2);
            edn   = (k == BURST - 1);
            eaddr = (k < BURST - 1) ? ADDR_W'(k / RC) : ADDR_W'(ROWS - 1);
            vectors++;
            if ({mem_rd_en, mem_wr_en, done, busy} !== {erd, ewr, edn, 1'b1} || mem_addr !== eaddr) begin
                miscompares++;
                $display("FAIL burst_k%0d: rd/wr/done/busy=%b addr=%0d, expected %b addr=%0d",
                         k, {mem_rd_en, mem_wr_en, done, busy}, mem_addr, {erd, ewr, edn, 1'b1}, eaddr);
            end
            tick();
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_end: busy=%b done=%b, expected 0/0", busy, done);
        end
        repeat (10) tick();
        vectors++;
        if (rd_cnt - base_rd != RDS || done_cnt - base_done != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_pend: reads=%0d dones=%0d busy=%b, expected %0d/1/0",
                     rd_cnt - base_rd, done_cnt - base_done, busy, RDS);
        end
        for (int r = 0; r < ROWS; r++) begin
            vectors++;
            if (mem[r] !== orig[r]) begin
                miscompares++;
                $display("FAIL row_data_r%0d: got %h, expected %h", r, mem[r], orig[r]);
            end
        end
    endtask

    task automatic test_pause();
        bit ok;
        int base_done;
        base_done = done_cnt;
        ref_req = 1'b1; tick(); ref_req = 1'b0;
        wait_rd("pause_start", 20, ok);
        if (!ok) return;
        repeat (RC) tick();
        vectors++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 2'd1) begin
            miscompares++;
            $display("FAIL pause_row1_read: rd=%b addr=%0d, expected 1/1", mem_rd_en, mem_addr);
        end
        user_active = 1'b1;
        tick(); tick();
        vectors++;
        if (mem_wr_en !== 1'b1 || mem_addr !== 2'd1) begin
            miscompares++;
            $display("FAIL pause_row1_write: wr=%b addr=%0d, expected 1/1", mem_wr_en, mem_addr);
        end
        repeat (RC - 2) tick();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({busy, mem_rd_en, mem_wr_en} !== 3'b100 || mem_addr !== 2'd1) begin
                miscompares++;
                $display("FAIL pause_hold_c%0d: busy/rd/wr=%b addr=%0d, expected 100 addr=1",
                         i, {busy, mem_rd_en, mem_wr_en}, mem_addr);
            end
            tick();
        end
        user_active = 1'b0;
        tick();
        vectors++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 2'd2) begin
            miscompares++;
            $display("FAIL pause_resume: rd=%b addr=%0d, expected 1/2", mem_rd_en, mem_addr);
        end
        wait_done("pause_done", 60, ok);
        repeat (5) tick();
        vectors++;
        if (done_cnt - base_done != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL pause_finish: dones=%0d busy=%b, expected 1/0", done_cnt - base_done, busy);
        end
    endtask

    task automatic test_overflow();
        int base_rd, base_wr, base_done, n, nd;
        int dn [3];
        disable_ref = 1'b1;
        base_rd = rd_cnt;
        base_wr = wr_cnt;
        base_done = done_cnt;
        for (int p = 1; p <= 5; p++) begin
            ref_req = 1'b1;
            tick();
            vectors++;
            if (overflow !== (p >= 4)) begin
                miscompares++;
                $display("FAIL ovf_p%0d: overflow=%b, expected %b", p, overflow, (p >= 4));
            end
        end
        ref_req = 1'b0;
        repeat (5) tick();
        vectors++;
        if (busy !== 1'b0 || rd_cnt != base_rd || wr_cnt != base_wr) begin
            miscompares++;
            $display("FAIL ovf_quiet: busy=%b reads=%0d writes=%0d, expected 0/0/0",
                     busy, rd_cnt - base_rd, wr_cnt - base_wr);
        end
        disable_ref = 1'b0;
        n = 0;
        nd = 0;
        while (nd < 3 && n < 3 * (BURST + 1) + 20) begin
            tick();
            n++;
            if (done === 1'b1) begin
                dn[nd] = n;
                nd++;
            end
        end
        for (int j = 0; j < 3; j++) begin
            vectors++;
            if (j >= nd || dn[j] != BURST + j * (BURST + 1)) begin
                miscompares++;
                $display("FAIL ovf_burst%0d: done at cycle %0d (found %0d dones), expected %0d",
                         j, (j < nd) ? dn[j] : -1, nd, BURST + j * (BURST + 1));
            end
        end
        repeat (20) tick();
        vectors++;
        if (done_cnt - base_done != 3 || rd_cnt - base_rd != 3 * RDS || overflow !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_final: dones=%0d reads=%0d ovf=%b busy=%b, expected 3/%0d/1/0",
                     done_cnt - base_done, rd_cnt - base_rd, overflow, busy, 3 * RDS);
        end
    endtask

    task automatic test_done_coincident();
        bit ok;
        int base_done;
        base_done = done_cnt;
        ref_req = 1'b1; tick(); ref_req = 1'b0;
        wait_done("coinc_first", BURST + 10, ok);
        if (!ok) return;
        ref_req = 1'b1; tick(); ref_req = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL coinc_idle: busy=%b done=%b, expected 0/0", busy, done);
        end
        tick();
        vectors++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 2'd0) begin
            miscompares++;
            $display("FAIL coinc_restart: rd=%b addr=%0d, expected 1/0", mem_rd_en, mem_addr);
        end
        wait_done("coinc_second", BURST + 10, ok);
        repeat (15) tick();
        vectors++;
        if (done_cnt - base_done != 2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL coinc_pend: dones=%0d busy=%b, expected 2/0", done_cnt - base_done, busy);
        end
    endtask

    task automatic test_reset_midburst();
        bit ok;
        int base_wr, base_rd;
        ref_req = 1'b1; tick(); ref_req = 1'b0;
        wait_rd("rstmid_start", 20, ok);
        if (!ok) return;
        repeat (2 * RC + 1) tick();
        vectors++;
        if ({busy, mem_rd_en, mem_wr_en} !== 3'b100 || mem_addr !== 2'd2) begin
            miscompares++;
            $display("FAIL rstmid_wait: busy/rd/wr=%b addr=%0d, expected 100 addr=2",
                     {busy, mem_rd_en, mem_wr_en}, mem_addr);
        end
        base_wr = wr_cnt;
        rst = 1'b0;
        tick();
        vectors++;
        if ({busy, done, overflow, mem_rd_en, mem_wr_en} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: ctrl=%b addr=%0d wdata=%h, expected 00000/0/0",
                     {busy, done, overflow, mem_rd_en, mem_wr_en}, mem_addr, mem_wdata);
        end
        sb.delete();
        rst = 1'b1;
        base_rd = rd_cnt;
        repeat (20) tick();
        vectors++;
        if (wr_cnt != base_wr || rd_cnt != base_rd || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_after: writes=%0d reads=%0d busy=%b, expected 0/0/0",
                     wr_cnt - base_wr, rd_cnt - base_rd, busy);
        end
    endtask

`ifdef REFRESH_VERIFY_EN
    task automatic test_verify();
        bit ok;
        int base_done;
        base_done = done_cnt;
        vectors++;
        if (verify_err !== 1'b0) begin
            miscompares++;
            $display("FAIL verify_init: verify_err=%b, expected 0", verify_err);
        end
        corrupt = 1'b1;
        ref_req = 1'b1; tick(); ref_req = 1'b0;
        wait_done("verify_done", BURST + 10, ok);
        vectors++;
        if (verify_err !== 1'b1) begin
            miscompares++;
            $display("FAIL verify_flag: verify_err=%b, expected 1", verify_err);
        end
        corrupt = 1'b0;
        repeat (5) tick();
        vectors++;
        if (verify_err !== 1'b1 || done_cnt - base_done != 1) begin
            miscompares++;
            $display("FAIL verify_sticky: verify_err=%b dones=%0d, expected 1/1", verify_err, done_cnt - base_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_pause();
        test_overflow();
        test_done_coincident();
        test_reset_midburst();
`ifdef REFRESH_VERIFY_EN
        test_verify();
`endif
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d reads never written back, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
